// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: prescaled BCD MM..M:SS stopwatch with start/pause/clear FSM and wrap pulse
// Optional lap freeze of the displayed count when BCD_STOPWATCH_LAP_EN is defined.
module bcd_stopwatch #(
  parameter int PRESCALE   = 1,
  parameter int PRESCALE_W = 16,
  parameter int MIN_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    clear,
  input  logic                    lap,
  output logic [3:0]              sec_ones,
  output logic [2:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] min_bcd,
  output logic                    running,
  output logic                    overflow
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state_q, state_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [3:0] ones_q, ones_d;
  logic [2:0] tens_q, tens_d;
  logic [MIN_DIGITS-1:0][3:0] min_q, min_d;
  logic running_q, ovf_q, step, wrap;
  always_comb begin
    logic c;
    state_d = start_stop ? (state_q == RUN ? PAUSE : RUN) : state_q;
    step = (state_q == RUN) && (pre_q == PRESCALE_W'(PRESCALE - 1));
    pre_d = state_q != RUN ? pre_q : step ? '0 : pre_q + 1'b1;
    ones_d = step ? (ones_q == 4'd9 ? 4'd0 : ones_q + 4'd1) : ones_q;
    c = step && ones_q == 4'd9;
    tens_d = c ? (tens_q == 3'd5 ? 3'd0 : tens_q + 3'd1) : tens_q;
    c = c && tens_q == 3'd5;
    min_d = min_q;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      min_d[i] = c ? (min_q[i] == 4'd9 ? 4'd0 : min_q[i] + 4'd1) : min_q[i];
      c = c && min_q[i] == 4'd9;
    end
    wrap = c;
  end
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      ones_q    <= '0;
      tens_q    <= '0;
      min_q     <= '0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      min_q     <= min_d;
      running_q <= state_d == RUN;
      ovf_q     <= wrap;
    end
  end
  assign running  = running_q;
  assign overflow = ovf_q;
`ifdef BCD_STOPWATCH_LAP_EN
  logic frz_q;
  logic [3:0] snap_ones_q;
  logic [2:0] snap_tens_q;
  logic [MIN_DIGITS-1:0][3:0] snap_min_q;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      frz_q       <= 1'b0;
      snap_ones_q <= '0;
      snap_tens_q <= '0;
      snap_min_q  <= '0;
    end else if (lap && state_q == RUN) begin
      frz_q <= !frz_q;
      if (!frz_q) begin
        snap_ones_q <= ones_q;
        snap_tens_q <= tens_q;
        snap_min_q  <= min_q;
      end
    end
  end
  assign sec_ones = frz_q ? snap_ones_q : ones_q;
  assign sec_tens = frz_q ? snap_tens_q : tens_q;
  assign min_bcd  = frz_q ? snap_min_q : min_q;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign sec_ones   = ones_q;
  assign sec_tens   = tens_q;
  assign min_bcd    = min_q;
`endif
endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: directed checks of three stopwatch configurations (default, PRESCALE=4, MIN_DIGITS=1)
module tb_bcd_stopwatch;
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] ss = '0, cl = '0, lp = '0;
  logic [3:0] so0, so1, so2, mn2;
  logic [2:0] st0, st1, st2;
  logic [7:0] mn0, mn1;
  logic rn0, rn1, rn2, ov0, ov1, ov2;
  int pass = 0, total = 0;
  typedef struct {logic ss, clr; int o, t, m, r;} vec_t;
  vec_t tv[10];
  always #5 clk = ~clk;
  bcd_stopwatch u0 (.clk(clk), .reset(reset), .start_stop(ss[0]), .clear(cl[0]), .lap(lp[0]),
    .sec_ones(so0), .sec_tens(st0), .min_bcd(mn0), .running(rn0), .overflow(ov0));
  bcd_stopwatch #(.PRESCALE(4)) u1 (.clk(clk), .reset(reset), .start_stop(ss[1]), .clear(cl[1]), .lap(lp[1]),
    .sec_ones(so1), .sec_tens(st1), .min_bcd(mn1), .running(rn1), .overflow(ov1));
  bcd_stopwatch #(.MIN_DIGITS(1)) u2 (.clk(clk), .reset(reset), .start_stop(ss[2]), .clear(cl[2]), .lap(lp[2]),
    .sec_ones(so2), .sec_tens(st2), .min_bcd(mn2), .running(rn2), .overflow(ov2));
  task automatic tick();
    @(posedge clk);
    #1 ss = '0; cl = '0; lp = '0;
    @(negedge clk);
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  function automatic logic [31:0] ex(int o, int t, int m, int r, int v);
    return {15'd0, o[3:0], t[2:0], m[7:0], r[0], v[0]};
  endfunction
  function automatic logic [31:0] ex2(int o, int t, int m, int r, int v);
    return {19'd0, o[3:0], t[2:0], m[3:0], r[0], v[0]};
  endfunction
  function automatic logic [31:0] s0();
    return {15'd0, so0, st0, mn0, rn0, ov0};
  endfunction
  function automatic logic [31:0] s1();
    return {15'd0, so1, st1, mn1, rn1, ov1};
  endfunction
  function automatic logic [31:0] s2();
    return {19'd0, so2, st2, mn2, rn2, ov2};
  endfunction
  initial begin
    tv[0] = '{1'b1, 1'b0, 0, 0, 0, 1};
    tv[1] = '{1'b0, 1'b0, 1, 0, 0, 1};
    tv[2] = '{1'b0, 1'b0, 2, 0, 0, 1};
    tv[3] = '{1'b1, 1'b0, 3, 0, 0, 0};
    tv[4] = '{1'b0, 1'b0, 3, 0, 0, 0};
    tv[5] = '{1'b1, 1'b0, 3, 0, 0, 1};
    tv[6] = '{1'b0, 1'b0, 4, 0, 0, 1};
    tv[7] = '{1'b1, 1'b1, 0, 0, 0, 0};
    tv[8] = '{1'b0, 1'b0, 0, 0, 0, 0};
    tv[9] = '{1'b0, 1'b1, 0, 0, 0, 0};
    @(negedge clk);
    run(2);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle%0d", i), s0(), ex(0, 0, 0, 0, 0));
    end
    chk("idle_u1", s1(), ex(0, 0, 0, 0, 0));
    chk("idle_u2", s2(), ex2(0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      ss[0] = tv[i].ss;
      cl[0] = tv[i].clr;
      tick();
      chk($sformatf("vec%0d", i), s0(), ex(tv[i].o, tv[i].t, tv[i].m, tv[i].r, 0));
    end
    ss[0] = 1'b1;
    tick();
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 9) chk("roll9", s0(), ex(9, 0, 0, 1, 0));
      if (k == 10) chk("roll10", s0(), ex(0, 1, 0, 1, 0));
      if (k == 60) chk("roll60", s0(), ex(0, 0, 1, 1, 0));
    end
    cl[0] = 1'b1;
    tick();
    chk("clear_run", s0(), ex(0, 0, 0, 0, 0));
    ss[0] = 1'b1;
    tick();
    run(37);
    chk("at_0_37", s0(), ex(7, 3, 0, 1, 0));
    cl[0] = 1'b1;
    ss[0] = 1'b1;
    tick();
    chk("clr_wins", s0(), ex(0, 0, 0, 0, 0));
    tick();
    chk("clr_idle", s0(), ex(0, 0, 0, 0, 0));
    ss[0] = 1'b1;
    tick();
    run(12);
    chk("lap_pre", s0(), ex(2, 1, 0, 1, 0));
    lp[0] = 1'b1;
    tick();
`ifdef BCD_STOPWATCH_LAP_EN
    chk("lap_frz", s0(), ex(2, 1, 0, 1, 0));
    run(3);
    chk("lap_hold", s0(), ex(2, 1, 0, 1, 0));
`else
    chk("lap_live", s0(), ex(3, 1, 0, 1, 0));
    run(3);
    chk("lap_live2", s0(), ex(6, 1, 0, 1, 0));
`endif
    lp[0] = 1'b1;
    tick();
    chk("lap_rel", s0(), ex(7, 1, 0, 1, 0));
    tick();
    chk("lap_after", s0(), ex(8, 1, 0, 1, 0));
    ss[1] = 1'b1;
    tick();
    chk("ps_start", s1(), ex(0, 0, 0, 1, 0));
    run(3);
    chk("ps_wait", s1(), ex(0, 0, 0, 1, 0));
    tick();
    chk("ps_step1", s1(), ex(1, 0, 0, 1, 0));
    tick();
    ss[1] = 1'b1;
    tick();
    chk("ps_pause", s1(), ex(1, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("ps_hold%0d", i), s1(), ex(1, 0, 0, 0, 0));
    end
    ss[1] = 1'b1;
    tick();
    chk("ps_resume", s1(), ex(1, 0, 0, 1, 0));
    tick();
    chk("ps_res1", s1(), ex(1, 0, 0, 1, 0));
    tick();
    chk("ps_step2", s1(), ex(2, 0, 0, 1, 0));
    ss[2] = 1'b1;
    tick();
    run(599);
    chk("wrap_max", s2(), ex2(9, 5, 9, 1, 0));
    tick();
    chk("wrap_zero", s2(), ex2(0, 0, 0, 1, 1));
    tick();
    chk("wrap_cont", s2(), ex2(1, 0, 0, 1, 0));
    reset = 1'b1;
    ss[0] = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_u0", s0(), ex(0, 0, 0, 0, 0));
    chk("rst_u2", s2(), ex2(0, 0, 0, 0, 0));
    tick();
    chk("rst_idle", s0(), ex(0, 0, 0, 0, 0));
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
